// File: rtl/i2s_rx.sv
// I2S receiver. Oversamples an external sclk/lrclk/sdi triple in the clk domain,
// deserialises left and right samples MSB first with the I2S one-bit delay, and
// writes each completed stereo pair to a downstream FIFO with a single wr_en strobe.
//
// Ports:
//   clk        fabric clock, at least 4x the sclk frequency
//   rst        asynchronous active-low reset
//   sclk       I2S bit clock (asynchronous)
//   lrclk      I2S word select, 0 = left, 1 = right
//   sdi        I2S serial data
//   l_sample   captured left sample, valid while wr_en = 1
//   r_sample   captured right sample, valid while wr_en = 1
//   wr_en      one-clk FIFO write strobe
//   wr_ready   FIFO not full
//   overflow   sticky: a pair was dropped because wr_ready was low
//   short_err  sticky: a slot ended with fewer than DW bits
//   clr_err    synchronous clear of overflow and short_err (a set wins over it)
module i2s_rx #(
   parameter int unsigned DW = 24  // must be at least 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          sclk,
   input  logic          lrclk,
   input  logic          sdi,
   output logic [DW-1:0] l_sample,
   output logic [DW-1:0] r_sample,
   output logic          wr_en,
   input  logic          wr_ready,
   output logic          overflow,
   output logic          short_err,
   input  logic          clr_err
);

   localparam logic [DW-1:0] MsbOne   = {1'b1, {(DW-1){1'b0}}};
   localparam logic [DW-1:0] LsbOne   = {{(DW-1){1'b0}}, 1'b1};
   localparam logic [DW-1:0] PtrStart = MsbOne >> 1;

   typedef enum logic [1:0] {StAlign, StLeft, StRight} state_e;

   logic sclk_s1, sclk_s2, lr_s1, lr_s2, sdi_s1, sdi_s2;
   logic sclk_d, rise, lr_now, bit_now;

   // Two-flop synchronisers, then a registered rise pulse with lrclk/sdi delayed
   // alongside so all three stay aligned.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sclk_s1 <= 1'b0;
         sclk_s2 <= 1'b0;
         lr_s1   <= 1'b0;
         lr_s2   <= 1'b0;
         sdi_s1  <= 1'b0;
         sdi_s2  <= 1'b0;
         sclk_d  <= 1'b0;
         rise    <= 1'b0;
         lr_now  <= 1'b0;
         bit_now <= 1'b0;
      end else begin
         sclk_s1 <= sclk;
         sclk_s2 <= sclk_s1;
         lr_s1   <= lrclk;
         lr_s2   <= lr_s1;
         sdi_s1  <= sdi;
         sdi_s2  <= sdi_s1;
         sclk_d  <= sclk_s2;
         rise    <= sclk_s2 & ~sclk_d;
         lr_now  <= lr_s2;
         bit_now <= sdi_s2;
      end
   end

   state_e        state;
   logic          lr_p1, lr_p2;
   logic [DW-1:0] l_sr, r_sr;
   logic [DW-1:0] ptr;        // one-hot bit position to fill next; zero once the slot is full
   logic [DW-1:0] pair_l, pair_r;
   logic          emit, short_hit;
   logic          msb_left, msb_right;
   logic [DW-1:0] fill, first;

   // The bit at a rise belongs to the channel seen at the previous rise; a change
   // between the previous two rises marks it as that channel's MSB.
   always_comb begin
      msb_left  = rise & (lr_p1 != lr_p2) & ~lr_p1;
      msb_right = rise & (lr_p1 != lr_p2) & lr_p1;
      fill      = ptr & {DW{bit_now}};
      first     = MsbOne & {DW{bit_now}};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= StAlign;
         lr_p1     <= 1'b0;
         lr_p2     <= 1'b0;
         l_sr      <= '0;
         r_sr      <= '0;
         ptr       <= '0;
         pair_l    <= '0;
         pair_r    <= '0;
         emit      <= 1'b0;
         short_hit <= 1'b0;
      end else begin
         emit      <= 1'b0;
         short_hit <= 1'b0;
         if (rise) begin
            lr_p2 <= lr_p1;
            lr_p1 <= lr_now;
            case (state)
               StAlign: begin
                  if (msb_left) begin
                     l_sr  <= first;
                     ptr   <= PtrStart;
                     state <= StLeft;
                  end
               end
               StLeft: begin
                  if (msb_right) begin
                     short_hit <= (ptr != '0);
                     r_sr      <= first;
                     ptr       <= PtrStart;
                     state     <= StRight;
                  end else if (msb_left) begin
                     l_sr <= first;
                     ptr  <= PtrStart;
                  end else begin
                     l_sr <= l_sr | fill;
                     ptr  <= ptr >> 1;
                  end
               end
               StRight: begin
                  if (msb_left) begin
                     // A non-empty pointer means the pair has not gone out yet.
                     if (ptr != '0) begin
                        emit      <= 1'b1;
                        short_hit <= 1'b1;
                        pair_l    <= l_sr;
                        pair_r    <= r_sr;
                     end
                     l_sr  <= first;
                     ptr   <= PtrStart;
                     state <= StLeft;
                  end else if (msb_right) begin
                     r_sr <= first;
                     ptr  <= PtrStart;
                  end else begin
                     r_sr <= r_sr | fill;
                     ptr  <= ptr >> 1;
                     if (ptr == LsbOne) begin
                        emit   <= 1'b1;
                        pair_l <= l_sr;
                        pair_r <= r_sr | fill;
                     end
                  end
               end
               default: state <= StAlign;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_en     <= 1'b0;
         l_sample  <= '0;
         r_sample  <= '0;
         overflow  <= 1'b0;
         short_err <= 1'b0;
      end else begin
         wr_en <= emit & wr_ready;
         if (emit && wr_ready) begin
            l_sample <= pair_l;
            r_sample <= pair_r;
         end
         overflow  <= (emit & ~wr_ready) | (overflow & ~clr_err);
         short_err <= short_hit | (short_err & ~clr_err);
      end
   end

endmodule

// File: tb/tb_i2s_rx.sv
// Testbench for i2s_rx: drives an I2S stream (sclk = clk/8) built from per-slot
// words, predicts each pair from the slot contents and checks wr_en pulses
// through a scoreboard queue popped by an independent monitor.
module tb_i2s_rx;
   localparam int unsigned DW = 24;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          sclk = 1'b0;
   logic          lrclk = 1'b0;
   logic          sdi = 1'b0;
   logic          wr_ready = 1'b1;
   logic          clr_err = 1'b0;
   logic [DW-1:0] l_sample, r_sample;
   logic          wr_en, overflow, short_err;

   i2s_rx #(.DW(DW)) dut (
      .clk(clk), .rst(rst), .sclk(sclk), .lrclk(lrclk), .sdi(sdi),
      .l_sample(l_sample), .r_sample(r_sample), .wr_en(wr_en),
      .wr_ready(wr_ready), .overflow(overflow), .short_err(short_err),
      .clr_err(clr_err)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [DW-1:0] l;
      logic [DW-1:0] r;
      logic          chk_lat;
   } pair_t;

   pair_t         exp_q[$];
   int unsigned   e0_q[$];
   int            checks = 0;
   int            errors = 0;
   logic          carry = 1'b0;
   logic [DW-1:0] last_l = '0;
   logic [DW-1:0] last_r = '0;
   bit            seen;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Expected sample: the first n transmitted bits of the slot, MSB first,
   // truncated or zero-padded to DW bits.
   function automatic logic [DW-1:0] slot_val(input logic [31:0] w, input int n);
      logic [31:0] kept;
      kept = (n >= 32) ? w : (w & ~(32'hFFFF_FFFF >> n));
      return kept[31 -: DW];
   endfunction

   // One sclk period; inputs change while sclk falls. 'mark' records the clk
   // edge at which raw sclk is first seen high.
   task automatic sclk_cycle(input logic lr, input logic d, input bit mark);
      sclk  = 1'b0;
      lrclk = lr;
      sdi   = d;
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      if (mark) e0_q.push_back(cyc + 1);
      repeat (4) @(negedge clk);
   endtask

   // Slot bit j of word w (j = 0 is w[31]) goes out one sclk after the slot starts;
   // the first cycle of each slot carries the previous slot's last bit.
   task automatic send_slot(input logic ch, input logic [31:0] w, input int n,
                            input int rel_at, input bit mark_lat);
      logic d;
      for (int i = 0; i < n; i++) begin
         if (i == rel_at) rst = 1'b1;
         d = (i == 0) ? carry : w[32 - i];
         sclk_cycle(ch, d, mark_lat && (i == int'(DW)));
      end
      carry = w[32 - n];
   endtask

   task automatic send_frame(input logic [31:0] lw, input logic [31:0] rw, input int n,
                             input bit ready);
      pair_t p;
      wr_ready = ready;
      if (ready) begin
         p.l     = slot_val(lw, n);
         p.r     = slot_val(rw, n);
         p.chk_lat = (n >= int'(DW));
         exp_q.push_back(p);
         last_l = p.l;
         last_r = p.r;
      end
      send_slot(1'b0, lw, n, -1, 1'b0);
      send_slot(1'b1, rw, n, -1, ready && (n >= int'(DW)));
   endtask

   task automatic preamble();
      send_slot(1'b1, $urandom, 32, -1, 1'b0);
   endtask

   // Starts the next left slot so a pending right LSB / short pair is flushed,
   // then stops sclk.
   task automatic tail();
      for (int i = 0; i < 3; i++) sclk_cycle(1'b0, (i == 0) ? carry : 1'($urandom), 1'b0);
      sclk = 1'b0;
      repeat (40) @(negedge clk);
   endtask

   task automatic do_reset();
      rst      = 1'b0;
      wr_ready = 1'b1;
      clr_err  = 1'b0;
      sclk     = 1'b0;
      lrclk    = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_wr_en", 32'(wr_en), 0);
      check("rst_l_sample", 32'(l_sample), 0);
      check("rst_r_sample", 32'(r_sample), 0);
      check("rst_overflow", 32'(overflow), 0);
      check("rst_short_err", 32'(short_err), 0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   pair_t       mon_p;
   int unsigned mon_e0;
   int unsigned mon_lat;

   always @(negedge clk) begin
      if (wr_en === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_wr_en: got pulse l=%h r=%h expected none", l_sample, r_sample);
         end else begin
            mon_p = exp_q.pop_front();
            check("l_sample", 32'(l_sample), 32'(mon_p.l));
            check("r_sample", 32'(r_sample), 32'(mon_p.r));
            if (mon_p.chk_lat) begin
               checks++;
               if (e0_q.size() == 0) begin
                  errors++;
                  $display("FAIL latency: got pulse with no reference edge expected one");
               end else begin
                  mon_e0  = e0_q.pop_front();
                  mon_lat = cyc - mon_e0;
                  if (mon_lat < 3 || mon_lat > 5) begin
                     errors++;
                     $display("FAIL latency: got %0d clk expected 3..5", mon_lat);
                  end
               end
            end
         end
      end
   end

   initial begin
      @(negedge clk);
      do_reset();

      // Fixed frame followed by three back-to-back random frames, 32-bit slots.
      preamble();
      send_frame({24'hA5C3F1, 8'($urandom)}, {24'h123456, 8'($urandom)}, 32, 1'b1);
      for (int f = 0; f < 3; f++) send_frame($urandom, $urandom, 32, 1'b1);
      tail();
      check("pending_frames", exp_q.size(), 0);
      check("hold_l", 32'(l_sample), 32'(last_l));
      check("hold_r", 32'(r_sample), 32'(last_r));
      check("short_err_clean", 32'(short_err), 0);
      check("overflow_clean", 32'(overflow), 0);

      // Reset held through a left slot and released mid-right slot.
      rst = 1'b0;
      repeat (2) @(negedge clk);
      send_slot(1'b0, $urandom, 32, -1, 1'b0);
      send_slot(1'b1, $urandom, 32, 10, 1'b0);
      for (int f = 0; f < 2; f++) send_frame($urandom, $urandom, 32, 1'b1);
      tail();
      check("pending_after_reset", exp_q.size(), 0);
      check("short_err_after_reset", 32'(short_err), 0);

      // 16-bit slots: zero-padded samples, short_err, emit at the next left MSB.
      do_reset();
      preamble();
      send_frame({16'hFFFF, 16'($urandom)}, {16'h8001, 16'($urandom)}, 16, 1'b1);
      tail();
      check("pending_short", exp_q.size(), 0);
      check("short_l", 32'(l_sample), 32'hFFFF00);
      check("short_r", 32'(r_sample), 32'h800100);
      check("short_err_set", 32'(short_err), 1);

      // Dropped pair, clear, then a normal frame after a paused sclk.
      do_reset();
      preamble();
      send_frame($urandom, $urandom, 32, 1'b0);
      check("overflow_set", 32'(overflow), 1);
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      @(negedge clk);
      check("overflow_cleared", 32'(overflow), 0);
      send_frame($urandom, $urandom, 32, 1'b1);
      check("pending_after_clear", exp_q.size(), 0);

      // clr_err held until overflow appears, so it coincides with the set cycle.
      fork
         send_frame($urandom, $urandom, 32, 1'b0);
         begin
            seen    = 1'b0;
            clr_err = 1'b1;
            for (int k = 0; k < 800 && !seen; k++) begin
               @(negedge clk);
               if (overflow === 1'b1) seen = 1'b1;
            end
            clr_err = 1'b0;
            checks++;
            if (!seen) begin
               errors++;
               $display("FAIL set_beats_clear: got overflow=0 expected 1 within 800 clk");
            end
         end
      join
      repeat (5) @(negedge clk);
      check("overflow_kept", 32'(overflow), 1);
      check("short_err_overflow_run", 32'(short_err), 0);
      tail();

      check("pending_final", exp_q.size(), 0);
      check("latency_refs_final", e0_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
